ram_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the CPU's 16x1024 RAM.
- Accepts a byte stream from a UART receiver over a valid/ready handshake.
- Packs bytes high-byte-first into 16-bit words and writes them to sequential RAM addresses starting at 0.
- Holds the CPU off the RAM until the load completes, then reports done plus a running 16-bit checksum.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/ram_loader_if.sv | 30 +++
 rtl/ram_loader.sv | 131 +++++++++++++
 tb/tb_ram_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU/RAM definitions: loader FSM states and RAM geometry constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Geometry of the CPU's program RAM, shared by the RAM, the CPU and the loader.
  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 16;

  // The loader always packs exactly two bytes per RAM word, high byte first.
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO,
    WRITE,
    DONE
  } state_e;

  // Modulo-2^16 accumulate used for the load checksum.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Interfaces between the UART byte source, the loader and the program RAM.
// Latency: n/a (wiring only).
// Backpressure: byte_stream_if is valid/ready; ram_wr_if is a plain strobe bus.
//
// byte_stream_if: byte_valid/byte_data from the producer, byte_ready from the consumer.
// ram_wr_if:      ram_write_en/ram_read_en/ram_addr/ram_din from the master to the RAM.

interface byte_stream_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  // master = byte producer (UART receiver), slave = byte consumer (loader)
  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

interface ram_wr_if import cpu_pkg::*; #(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);
  logic              ram_write_en;
  logic              ram_read_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;

  // master = whoever drives the RAM (loader), slave = the RAM itself
  modport master (output ram_write_en, output ram_read_en, output ram_addr, output ram_din);
  modport slave  (input ram_write_en, input ram_read_en, input ram_addr, input ram_din);
endinterface

// File: rtl/ram_loader.sv
// Boot loader: packs a UART byte stream high-byte-first into words written to RAM 0..WORD_COUNT-1.
// Latency: write strobe one cycle after the low byte is accepted; peak 1 word per 3 cycles.
// Backpressure: byte_ready is high only while waiting for a byte; it drops for the write cycle.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         single-cycle pulse starting a load; ignored while busy
//   byte_in       byte stream slave (byte_valid, byte_data, byte_ready)
//   ram           RAM write master (ram_write_en, ram_read_en, ram_addr, ram_din)
//   busy          load in progress
//   done          last load completed; stays set until the next start
//   cpu_hold      CPU must keep off the RAM (everywhere except after a completed load)
//   checksum      modulo-2^16 sum of the words written by the current or last load
module ram_loader import cpu_pkg::*; #(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int DATA_W     = RAM_DATA_W,
  // Legal range 1 .. 2**ADDR_W.
  parameter int WORD_COUNT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  byte_stream_if.slave  byte_in,
  ram_wr_if.master      ram,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic [15:0]   checksum
);

  // Address of the final word; the counter stops here, so it never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;
  logic [7:0]        hi_q,    hi_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] din_q,   din_d;
  logic [15:0]       csum_q,  csum_d;

  logic ready_c;
  logic write_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    din_d   = din_q;
    csum_d  = csum_q;
    ready_c = 1'b0;
    write_c = 1'b0;

    case (state_q)
      // A completed load behaves like idle: a new start re-arms everything.
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end

      WAIT_HI: begin
        ready_c = 1'b1;
        if (byte_in.byte_valid) begin
          hi_d    = byte_in.byte_data;
          state_d = WAIT_LO;
        end
      end

      WAIT_LO: begin
        ready_c = 1'b1;
        if (byte_in.byte_valid) begin
          din_d   = {hi_q, byte_in.byte_data};
          addr_d  = cnt_q;
          state_d = WRITE;
        end
      end

      // One-cycle write strobe; the checksum picks up the word being written.
      WRITE: begin
        write_c = 1'b1;
        csum_d  = csum_add(csum_q, din_q);
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = WAIT_HI;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      csum_q  <= csum_d;
    end
  end

  assign byte_in.byte_ready = ready_c;

  // Reset arriving in the write cycle must squash the strobe right away, not a cycle later.
  assign ram.ram_write_en = write_c & ~rst;
  // The RAM drops writes when read is also asserted, so read is never driven.
  assign ram.ram_read_en  = 1'b0;
  assign ram.ram_addr     = addr_q;
  assign ram.ram_din      = din_q;

  assign busy     = (state_q == WAIT_HI) || (state_q == WAIT_LO) || (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign cpu_hold = (state_q != DONE);
  assign checksum = csum_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a WORD_COUNT=4 instance and a WORD_COUNT=1 instance,
// each checked every cycle against a transaction-level model of the loader, plus literal
// expectations for the directed loads.
module tb_ram_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Bench-side drive, index 0 = WORD_COUNT 4 instance, index 1 = WORD_COUNT 1 instance.
  logic [1:0]      start_s;
  logic [1:0]      val_s;
  logic [1:0][7:0] dat_s;

  logic [1:0]       rdy, we_o, re_o, busy_o, done_o, hold_o;
  logic [1:0][9:0]  addr_o;
  logic [1:0][15:0] din_o, csum_o;

  byte_stream_if bs0 ();
  byte_stream_if bs1 ();
  ram_wr_if #(.ADDR_W(10), .DATA_W(16)) rw0 ();
  ram_wr_if #(.ADDR_W(10), .DATA_W(16)) rw1 ();

  assign bs0.byte_valid = val_s[0];
  assign bs0.byte_data  = dat_s[0];
  assign bs1.byte_valid = val_s[1];
  assign bs1.byte_data  = dat_s[1];
  assign rdy[0] = bs0.byte_ready;
  assign rdy[1] = bs1.byte_ready;
  assign we_o[0] = rw0.ram_write_en;
  assign we_o[1] = rw1.ram_write_en;
  assign re_o[0] = rw0.ram_read_en;
  assign re_o[1] = rw1.ram_read_en;
  assign addr_o[0] = rw0.ram_addr;
  assign addr_o[1] = rw1.ram_addr;
  assign din_o[0] = rw0.ram_din;
  assign din_o[1] = rw1.ram_din;

  ram_loader #(.ADDR_W(10), .DATA_W(16), .WORD_COUNT(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (start_s[0]),
    .byte_in  (bs0),
    .ram      (rw0),
    .busy     (busy_o[0]),
    .done     (done_o[0]),
    .cpu_hold (hold_o[0]),
    .checksum (csum_o[0])
  );

  ram_loader #(.ADDR_W(10), .DATA_W(16), .WORD_COUNT(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start_s[1]),
    .byte_in  (bs1),
    .ram      (rw1),
    .busy     (busy_o[1]),
    .done     (done_o[1]),
    .cpu_hold (hold_o[1]),
    .checksum (csum_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A load is "active" from the cycle after start until the final word's write cycle.
  // Bytes are accepted whenever the load is active and no write is pending; every second
  // accepted byte forms a word that is written (strobed) in the following cycle.
  int          wc [2];
  bit          m_act [2];
  bit          m_pend [2];
  bit          m_done [2];
  int          m_words [2];
  int          m_nbytes [2];
  logic [7:0]  m_hi [2];
  logic [15:0] m_din [2];
  logic [9:0]  m_addr [2];
  logic [15:0] m_sum [2];

  logic [15:0] ram_mem [2][1024];
  int          wr_cnt [2];
  bit          run_chk = 1'b0;

  task automatic model_reset(input int d);
    m_act[d] = 0; m_pend[d] = 0; m_done[d] = 0;
    m_words[d] = 0; m_nbytes[d] = 0;
    m_hi[d] = '0; m_din[d] = '0; m_addr[d] = '0; m_sum[d] = '0;
  endtask

  task automatic model_step(input int d);
    bit start_ok;
    check($sformatf("d%0d byte_ready", d), rdy[d], m_act[d] && !m_pend[d]);
    check($sformatf("d%0d write_en", d), we_o[d], m_pend[d] && !rst);
    check($sformatf("d%0d read_en", d), re_o[d], 1'b0);
    check($sformatf("d%0d busy", d), busy_o[d], m_act[d]);
    check($sformatf("d%0d done", d), done_o[d], m_done[d]);
    check($sformatf("d%0d cpu_hold", d), hold_o[d], !m_done[d]);
    check($sformatf("d%0d ram_addr", d), addr_o[d], m_addr[d]);
    check($sformatf("d%0d ram_din", d), din_o[d], m_din[d]);
    check($sformatf("d%0d checksum", d), csum_o[d], m_sum[d]);

    // Bench RAM records what the DUT actually wrote.
    if (we_o[d] === 1'b1) begin
      ram_mem[d][addr_o[d]] = din_o[d];
      wr_cnt[d]++;
    end

    if (rst) begin
      model_reset(d);
    end else begin
      start_ok = start_s[d] && !m_act[d];
      if (m_pend[d]) begin
        m_sum[d] = m_sum[d] + m_din[d];
        m_words[d]++;
        m_pend[d] = 0;
        if (m_words[d] == wc[d]) begin
          m_act[d]  = 0;
          m_done[d] = 1;
        end
      end else if (m_act[d] && val_s[d]) begin
        if ((m_nbytes[d] % 2) == 0) begin
          m_hi[d] = dat_s[d];
        end else begin
          m_din[d]  = {m_hi[d], dat_s[d]};
          m_addr[d] = 10'(m_words[d]);
          m_pend[d] = 1;
        end
        m_nbytes[d]++;
      end
      if (start_ok) begin
        m_act[d] = 1; m_done[d] = 0; m_sum[d] = '0;
        m_words[d] = 0; m_nbytes[d] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] tx_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [15:0] w);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  task automatic clear_ram(input int d);
    for (int i = 0; i < 1024; i++) ram_mem[d][i] = 16'hDEAD;
    wr_cnt[d] = 0;
  endtask

  task automatic start_load(input int d);
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
  endtask

  // Optional idle gap, then present the byte until accepted. While the loader is not
  // ready, valid/data are scrambled when garble is set, otherwise the byte is held.
  task automatic send_byte(input int d, input logic [7:0] b, input int maxgap, input bit garble);
    bit ok;
    int gap;
    ok  = 0;
    gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    for (int i = 0; i < gap; i++) begin
      val_s[d] = 1'b0;
      dat_s[d] = 8'($urandom);
      tick();
    end
    for (int i = 0; i < 64 && !ok; i++) begin
      if (rdy[d]) begin
        val_s[d] = 1'b1;
        dat_s[d] = b;
        ok = 1;
      end else if (garble) begin
        val_s[d] = 1'($urandom_range(0, 1));
        dat_s[d] = 8'($urandom);
      end else begin
        val_s[d] = 1'b1;
        dat_s[d] = b;
      end
      tick();
    end
    val_s[d] = 1'b0;
    if (!ok) check($sformatf("d%0d byte accept timeout", d), 1'b0, 1'b1);
  endtask

  task automatic send_all(input int d, input int maxgap, input bit garble);
    while (tx_q.size() > 0) send_byte(d, tx_q.pop_front(), maxgap, garble);
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 200 && !done_o[d]; i++) tick();
    check($sformatf("d%0d done reached", d), done_o[d], 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [15:0] words [4];
  logic [15:0] sum;

  initial begin
    wc[0] = 4;
    wc[1] = 1;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      clear_ram(d);
    end
    rst = 1'b1;
    start_s = '0;
    val_s = '0;
    dat_s = '0;
    tick();
    run_chk = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset/idle state.
    repeat (5) tick();
    check("idle cpu_hold", hold_o[0], 1'b1);
    check("idle busy", busy_o[0], 1'b0);
    check("idle done", done_o[0], 1'b0);
    check("idle write_en", we_o[0], 1'b0);
    check("idle read_en", re_o[0], 1'b0);
    check("idle byte_ready", rdy[0], 1'b0);

    // Full back-to-back load. Sum: 1234+ABCD=BE01, +0001=BE02, +FFFF wraps to BE01.
    clear_ram(0);
    start_load(0);
    push2(16'h1234); push2(16'hABCD); push2(16'h0001); push2(16'hFFFF);
    send_all(0, 0, 0);
    wait_done(0);
    tick();
    check("full cpu_hold", hold_o[0], 1'b0);
    check("full checksum", csum_o[0], 16'hBE01);
    check("model checksum", m_sum[0], 16'hBE01);
    check("full ram0", ram_mem[0][0], 16'h1234);
    check("full ram1", ram_mem[0][1], 16'hABCD);
    check("full ram2", ram_mem[0][2], 16'h0001);
    check("full ram3", ram_mem[0][3], 16'hFFFF);
    check("full write count", wr_cnt[0], 4);

    // Same bytes with random gaps and scrambled inputs while not ready.
    clear_ram(0);
    start_load(0);
    push2(16'h1234); push2(16'hABCD); push2(16'h0001); push2(16'hFFFF);
    send_all(0, 5, 1);
    wait_done(0);
    tick();
    check("gap checksum", csum_o[0], 16'hBE01);
    check("gap ram0", ram_mem[0][0], 16'h1234);
    check("gap ram1", ram_mem[0][1], 16'hABCD);
    check("gap ram2", ram_mem[0][2], 16'h0001);
    check("gap ram3", ram_mem[0][3], 16'hFFFF);
    check("gap write count", wr_cnt[0], 4);

    // Start pulsed while waiting for a low byte must be ignored.
    clear_ram(0);
    start_load(0);
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      words[i] = 16'($urandom);
      sum = sum + words[i];
      push2(words[i]);
    end
    send_byte(0, tx_q.pop_front(), 0, 0);
    start_load(0);
    send_all(0, 2, 1);
    wait_done(0);
    tick();
    check("ignored-start write count", wr_cnt[0], 4);
    check("ignored-start checksum", csum_o[0], sum);
    for (int i = 0; i < 4; i++)
      check($sformatf("ignored-start ram%0d", i), ram_mem[0][i], words[i]);

    // Restart after DONE.
    clear_ram(0);
    start_load(0);
    check("restart done cleared", done_o[0], 1'b0);
    check("restart cpu_hold", hold_o[0], 1'b1);
    check("restart busy", busy_o[0], 1'b1);
    for (int i = 0; i < 4; i++) push2(16'h0005);
    send_all(0, 1, 0);
    wait_done(0);
    tick();
    check("restart checksum", csum_o[0], 16'h0014);
    for (int i = 0; i < 4; i++)
      check($sformatf("restart ram%0d", i), ram_mem[0][i], 16'h0005);

    // Random loads.
    for (int k = 0; k < 3; k++) begin
      clear_ram(0);
      start_load(0);
      sum = '0;
      for (int i = 0; i < 4; i++) begin
        words[i] = 16'($urandom);
        sum = sum + words[i];
        push2(words[i]);
      end
      send_all(0, 3, 1);
      wait_done(0);
      tick();
      check($sformatf("rand%0d checksum", k), csum_o[0], sum);
      check($sformatf("rand%0d write count", k), wr_cnt[0], 4);
      for (int i = 0; i < 4; i++)
        check($sformatf("rand%0d ram%0d", k, i), ram_mem[0][i], words[i]);
    end

    // Reset in the write cycle of word 2.
    clear_ram(0);
    start_load(0);
    push2(16'h1122); push2(16'h3344); push2(16'h5566);
    send_all(0, 0, 0);
    rst = 1'b1;
    #1;
    check("reset-in-write write_en", we_o[0], 1'b0);
    tick();
    rst = 1'b0;
    check("post-reset busy", busy_o[0], 1'b0);
    check("post-reset done", done_o[0], 1'b0);
    check("post-reset cpu_hold", hold_o[0], 1'b1);
    check("post-reset byte_ready", rdy[0], 1'b0);
    check("post-reset ram_addr", addr_o[0], 10'd0);
    check("post-reset ram_din", din_o[0], 16'h0000);
    check("post-reset checksum", csum_o[0], 16'h0000);
    check("reset kept ram0", ram_mem[0][0], 16'h1122);
    check("reset kept ram1", ram_mem[0][1], 16'h3344);
    check("reset no ram2", ram_mem[0][2], 16'hDEAD);
    check("reset write count", wr_cnt[0], 2);
    repeat (3) tick();

    // Single-word load.
    clear_ram(1);
    start_load(1);
    push2(16'h8000);
    send_all(1, 2, 1);
    wait_done(1);
    tick();
    check("wc1 write count", wr_cnt[1], 1);
    check("wc1 ram0", ram_mem[1][0], 16'h8000);
    check("wc1 ram1 untouched", ram_mem[1][1], 16'hDEAD);
    check("wc1 checksum", csum_o[1], 16'h8000);
    check("wc1 cpu_hold", hold_o[1], 1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
